// File: rtl/uart_defs.sv
// Shared UART definitions: parity encodings, transmitter state encoding,
// default baud divider and the parity helper.
package uart_defs;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
    logic x;
    logic p;
    x = ^data;
    case (mode)
      PAR_ODD:  p = ~x;
      PAR_EVEN: p = x;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count.
// Shared by the transmitter and the future receiver.
module uart_baud_tick
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_baud_tick: CLKS_PER_BIT must be 2 or more");
  end

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running period counter, restarted by clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: valid/ready input, on-chip baud divider,
// 5..9 data bits, none/odd/even parity, 1 or 2 stop bits, registered txd.
module uart_tx_cfg
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic [1:0]    PAR_MODE  = 2'(PARITY);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be 2 or more");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic                 par_bit, par_bit_n;
  logic                 txd_n;
  logic                 tick;
  logic                 accept;
  logic                 last_stop;
  logic                 baud_clr;
  logic [8:0]           din_ext;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  // The last clock of the last stop bit doubles as an accept slot so
  // back-to-back frames have no idle gap.
  assign last_stop = (state == STOP) && tick && (bit_cnt == LAST_STOP);
  assign din_ready = !rst && ((state == IDLE) || last_stop);
  assign accept    = din_valid && din_ready;
  assign busy      = (state != IDLE);
  assign baud_clr  = accept || (state == IDLE);

  // Zero-extended copy of din for the parity helper.
  always_comb begin
    din_ext = 9'd0;
    din_ext[DATA_BITS-1:0] = din;
  end

  // State register and frame datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      par_bit <= par_bit_n;
      txd     <= txd_n;
    end
  end

  // Next-state, shift, bit count and parity capture.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_bit_n = par_bit;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          shift_n   = din;
          bit_cnt_n = '0;
          par_bit_n = calc_parity(din_ext, PAR_MODE);
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (PAR_MODE == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end else begin
          state_n = DATA;
        end
      end
      PAR: begin
        if (tick) begin
          state_n   = STOP;
          bit_cnt_n = '0;
        end else begin
          state_n = PAR;
        end
      end
      STOP: begin
        if (last_stop) begin
          bit_cnt_n = '0;
          if (accept) begin
            state_n   = START;
            shift_n   = din;
            par_bit_n = calc_parity(din_ext, PAR_MODE);
          end else begin
            state_n = IDLE;
          end
        end else if (tick) begin
          bit_cnt_n = bit_cnt + CW'(1);
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n   = IDLE;
        bit_cnt_n = '0;
      end
    endcase
  end

  // Line level for the current state, registered one clock later.
  always_comb begin
    txd_n = 1'b1;
    case (state)
      IDLE:    txd_n = 1'b1;
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift[0];
      PAR:     txd_n = par_bit;
      STOP:    txd_n = 1'b1;
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with an on-chip baud divider, a valid/ready input handshake, and configurable data width, parity and stop bits. It supersedes the fixed 8N1 transmitter that needed an external baud clock. Everything runs in the single system clock domain, with bit timing derived from a clock-enable tick. It sits between any byte producer (FIFO, command engine) and the board TXD pin.

## Interface
Parameters:
- CLKS_PER_BIT, 434: system clocks per bit (434 gives 115200 baud at 50 MHz). Legal values are 2 and up.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active high
- din  in  DATA_BITS  word to send, LSB first
- din_valid  in  1  producer has a word on din
- din_ready  out  1  block can accept a word this cycle
- txd  out  1  serial line; idles at 1
- busy  out  1  a frame is in progress

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Accept rule: a word is accepted on a clock edge where din_valid && din_ready.
  - On accept, din is copied into a shift register and the parity bit is computed from that copy.
  - Odd parity: the parity bit makes the total count of ones odd. Even parity: XOR of the data bits.
  - din is ignored at all other times.
- Bit timer: counts 0..CLKS_PER_BIT-1. A tick occurs at CLKS_PER_BIT-1. The timer is cleared on accept and held at 0 in IDLE.
- State transitions, each taken on a tick:
  - START → DATA.
  - DATA: shifts right on every tick; after DATA_BITS ticks it goes to PAR, or to STOP if PARITY=0.
  - PAR → STOP.
  - STOP: goes to IDLE after STOP_BITS ticks, unless a new word is accepted, in which case it goes to START.
- txd value per state: 1 in IDLE, 0 in START, shift[0] in DATA, parity bit in PAR, 1 in STOP.
- txd is driven from a register, so it has no glitches.
- din_ready: high in IDLE. It is also high in the final clock of the final stop bit, which allows back-to-back frames with no idle gap. It is low while rst=1.
- busy: high whenever the state is not IDLE.
- Reset:
  - Outputs: txd=1, busy=0, din_ready=0 while rst is held.
  - Internal: state=IDLE, timer=0, shift register=0.
  - Reset in the middle of a frame abandons the frame. txd returns to 1 on the next edge. No partial frame is resumed.
- din_valid deasserting in the same cycle as an accept has no effect: the accept has already happened.
- Illegal parameter values must stop elaboration (generate-time error).

## Timing
- Accept at edge k: txd goes to 0 at edge k+1. Each bit then lasts exactly CLKS_PER_BIT clocks.
- Frame length: F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) clocks. txd returns to idle-high at edge k+1+F.
- Isolated frame: din_ready goes high again F clocks after the accept edge.
- Back-to-back: if din_valid is held high, the next start bit begins at edge k+1+F, and txd never has an idle cycle between frames.
- Width of the bit timer is $clog2(CLKS_PER_BIT). Width of the bit counter is $clog2(DATA_BITS+1). Neither may wrap within a frame.

## Structure
- Shared header uart_defs holds:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - the state encodings;
  - the default CLKS_PER_BIT value.
- One sub-module, uart_baud_tick: a parameter CLKS_PER_BIT, inputs clk, rst and clr, output tick. The same block will be reused by the future receiver.
- The FSM, shift register and parity logic stay in uart_tx_cfg.

## Test plan
- CLKS_PER_BIT=4, 8N1, din=8'hA5 accepted at edge k. Required: txd sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 clocks, starting at edge k+1. busy is high for 40 clocks.
- PARITY=1 (odd), din=8'h03. Required: parity bit 1. Then PARITY=2 (even) with the same data. Required: parity bit 0.
- DATA_BITS=7, STOP_BITS=2, din_valid held high with words 7'h55 then 7'h2A. Required: second start bit begins immediately after the second stop bit. din_ready pulses for exactly 1 clock at the boundary.
- rst asserted for 1 cycle during bit 3 of a frame. Required: txd=1 on the next edge, busy=0, din_ready=1 one cycle after rst drops. The next frame is correct.
- din_valid pulsed while busy, with din changing during the frame. Required: the pulse is not accepted and the transmitted bits are unchanged.
- CLKS_PER_BIT=2 (minimum). Required: every bit lasts exactly 2 clocks and the frame is correct.
